// File: rtl/mem_stage_pkg.sv
// Shared opcode, width and strobe constants for the memory-access stage.
package mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_LDR = 4'b1000;
    localparam logic [OP_W-1:0] OP_STR = 4'b1001;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LDR) || (op == OP_STR);
    endfunction

endpackage

// File: rtl/mux_2by1.sv
// Purpose: 32-bit two-input selector; Out = In1 when Select is 0, In2 when 1.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module mux_2by1
    import mem_stage_pkg::*;
(
    input  logic              Select,
    input  logic [DATA_W-1:0] In1,
    input  logic [DATA_W-1:0] In2,
    output logic [DATA_W-1:0] Out
);

    assign Out = Select ? In2 : In1;

endmodule

// File: rtl/memory_access_block.sv
// Purpose: MEM stage; drives memory address/data/strobe and captures load data.
// Latency: address/data/strobe combinational; LDR valid one edge after a load.
// Backpressure: none; one access per cycle, memory must answer in-cycle.
module memory_access_block
    import mem_stage_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              ReadWrite,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] LDR,
    input  logic [DATA_W-1:0] Source1,
    input  logic [DATA_W-1:0] Source2,
    input  logic [DATA_W-1:0] Result,
    input  logic [OP_W-1:0]   OpCode,
    input  logic [ADDR_W-1:0] PCInstruction
);

    logic              is_ldr;
    logic              is_str;
    logic              is_mem;
    logic [DATA_W-1:0] addr_sel;

    assign is_ldr = (OpCode == OP_LDR);
    assign is_str = (OpCode == OP_STR);
    assign is_mem = is_mem_op(OpCode);

    // Both candidates are zero-extended; the upper half of the mux output is dropped.
    mux_2by1 u_addr_mux (
        .Select (is_mem),
        .In1    ({{(DATA_W-ADDR_W){1'b0}}, PCInstruction}),
        .In2    ({{(DATA_W-ADDR_W){1'b0}}, Result[ADDR_W-1:0]}),
        .Out    (addr_sel)
    );

    assign Address   = addr_sel[ADDR_W-1:0];
    assign ReadWrite = (is_str && !Reset) ? MEM_WRITE : MEM_READ;
    assign DataOut   = is_str ? Source2 : '0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            LDR <= '0;
        end else if (is_ldr) begin
            LDR <= DataIn;
        end
    end

    // Operand and address bits the stage deliberately does not use.
    logic unused_inputs;
    assign unused_inputs = ^{Source1, Result[DATA_W-1:ADDR_W], addr_sel[DATA_W-1:ADDR_W]};

endmodule

// File: tb/tb_memory_access_block.sv
module tb_memory_access_block;
    import mem_stage_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        ReadWrite;
    logic [15:0] Address;
    logic [31:0] LDR;
    logic [31:0] Source1;
    logic [31:0] Source2;
    logic [31:0] Result;
    logic [3:0]  OpCode;
    logic [15:0] PCInstruction;

    logic        mux_sel;
    logic [31:0] mux_a;
    logic [31:0] mux_b;
    logic [31:0] mux_o;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ldr_model;

    always #5 Clock = ~Clock;

    memory_access_block dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .DataIn        (DataIn),
        .DataOut       (DataOut),
        .ReadWrite     (ReadWrite),
        .Address       (Address),
        .LDR           (LDR),
        .Source1       (Source1),
        .Source2       (Source2),
        .Result        (Result),
        .OpCode        (OpCode),
        .PCInstruction (PCInstruction)
    );

    mux_2by1 u_mux (
        .Select (mux_sel),
        .In1    (mux_a),
        .In2    (mux_b),
        .Out    (mux_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] pc, input logic [31:0] res,
                         input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] din);
        OpCode        = op;
        PCInstruction = pc;
        Result        = res;
        Source1       = s1;
        Source2       = s2;
        DataIn        = din;
    endtask

    // Reference: load/store use the low 16 bits of Result, everything else fetches from PC.
    task automatic check_comb(input string tag);
        logic [31:0] exp_addr;
        logic [31:0] exp_rw;
        logic [31:0] exp_dout;
        if (OpCode == 4'd8 || OpCode == 4'd9)
            exp_addr = Result % 32'd65536;
        else
            exp_addr = {16'd0, PCInstruction};
        exp_rw   = (OpCode == 4'd9 && Reset == 1'b0) ? 32'd1 : 32'd0;
        exp_dout = (OpCode == 4'd9) ? Source2 : 32'd0;
        chk({tag, ".addr"}, {16'd0, Address}, exp_addr);
        chk({tag, ".rw"},   {31'd0, ReadWrite}, exp_rw);
        chk({tag, ".dout"}, DataOut, exp_dout);
    endtask

    task automatic edge_and_check(input string tag);
        @(posedge Clock);
        if (Reset)
            ldr_model = 32'd0;
        else if (OpCode == 4'd8)
            ldr_model = DataIn;
        #1;
        chk({tag, ".ldr"}, LDR, ldr_model);
    endtask

    initial begin
        ldr_model = 32'd0;
        mux_sel = 1'b0;
        mux_a = 32'd0;
        mux_b = 32'd0;

        // Reset held with a store opcode: no write may escape.
        Reset = 1'b1;
        drive(OP_STR, 16'h0010, 32'h0000_0020, 32'h0, 32'h0BAD_0BAD, 32'h7777_7777);
        #1;
        chk("reset.rw", {31'd0, ReadWrite}, 32'd0);
        chk("reset.ldr", LDR, 32'd0);
        edge_and_check("reset_edge");
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("release.rw", {31'd0, ReadWrite}, 32'd1);

        // Fetch
        @(negedge Clock);
        drive(4'b0000, 16'h0042, 32'h0000_1234, 32'h1, 32'h2, 32'h3333_3333);
        #1;
        chk("fetch.addr", {16'd0, Address}, 32'h0000_0042);
        check_comb("fetch");
        edge_and_check("fetch");

        // Store
        @(negedge Clock);
        drive(OP_STR, 16'h0042, 32'hFFFF_0100, 32'h9, 32'hDEAD_BEEF, 32'h4444_4444);
        #1;
        chk("store.addr", {16'd0, Address}, 32'h0000_0100);
        chk("store.rw", {31'd0, ReadWrite}, 32'd1);
        chk("store.dout", DataOut, 32'hDEAD_BEEF);
        edge_and_check("store");

        // Load
        @(negedge Clock);
        drive(OP_LDR, 16'h0042, 32'h0000_0200, 32'h9, 32'h5555_5555, 32'hCAFE_F00D);
        #1;
        chk("load.addr", {16'd0, Address}, 32'h0000_0200);
        chk("load.rw", {31'd0, ReadWrite}, 32'd0);
        chk("load.dout", DataOut, 32'd0);
        edge_and_check("load");
        chk("load.value", LDR, 32'hCAFE_F00D);

        // Reset arriving during a load cycle, held across the edge
        @(negedge Clock);
        drive(OP_LDR, 16'h0001, 32'h0000_0300, 32'h0, 32'h0, 32'h1111_1111);
        #1;
        Reset = 1'b1;
        #1;
        chk("midload.async_ldr", LDR, 32'd0);
        edge_and_check("midload");
        @(negedge Clock);
        Reset = 1'b0;
        drive(OP_LDR, 16'h0001, 32'h0000_0304, 32'h0, 32'h0, 32'h2222_2222);
        edge_and_check("after_reset_load");
        chk("after_reset_load.value", LDR, 32'h2222_2222);

        // Back-to-back loads
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            drive(OP_LDR, 16'h0, 32'h400 + i, 32'h0, 32'h0, $urandom);
            edge_and_check("b2b");
        end

        // Standalone selector
        mux_a = 32'hA5A5_A5A5;
        mux_b = 32'h5A5A_5A5A;
        mux_sel = 1'b0;
        #1;
        chk("mux.sel0", mux_o, 32'hA5A5_A5A5);
        mux_sel = 1'b1;
        #1;
        chk("mux.sel1", mux_o, 32'h5A5A_5A5A);

        // Randomized traffic, biased toward memory opcodes
        for (int i = 0; i < 200; i++) begin
            logic [3:0] op;
            @(negedge Clock);
            case ($urandom_range(0, 3))
                0:       op = OP_LDR;
                1:       op = OP_STR;
                default: op = 4'($urandom_range(0, 15));
            endcase
            Reset = ($urandom_range(0, 15) == 0);
            drive(op, 16'($urandom), $urandom, $urandom, $urandom, $urandom);
            #1;
            check_comb("rand");
            edge_and_check("rand");
            mux_sel = 1'($urandom);
            mux_a = $urandom;
            mux_b = $urandom;
            #1;
            chk("rand.mux", mux_o, mux_sel ? mux_b : mux_a);
        end
        @(negedge Clock);
        Reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_access_block.md
# memory_access_block

Memory-access (MEM) stage of the group's 32-bit datapath. It drives the unified memory's address, data and read/write strobe from the decoded opcode, the ALU result and the instruction-fetch address. For loads it captures the returned memory word into the LDR register for write-back. It sits between the execute stage (ALU `Result`, operands) and the write-back stage.

## Interface
Parameters: none; widths are fixed.
- `Clock` in 1: single system clock, rising-edge active.
- `Reset` in 1: asynchronous, active-high.
- `DataIn` in 32: read data returned by memory.
- `DataOut` out 32: write data driven to memory.
- `ReadWrite` out 1: memory strobe; 1 = write, 0 = read.
- `Address` out 16: memory address.
- `LDR` out 32: registered load data for write-back.
- `Source1` in 32: first register operand (unused for addressing; kept for stage uniformity).
- `Source2` in 32: second register operand; store data.
- `Result` in 32: ALU result; `Result[15:0]` is the load/store effective address.
- `OpCode` in 4: current instruction opcode.
- `PCInstruction` in 16: instruction-fetch address (PC).

## Operation
- Opcode decode:
  - `OP_LDR` = 4'b1000: load.
  - `OP_STR` = 4'b1001: store.
  - All other opcodes are non-memory.
- Address select is a 2:1 mux with select `IsMem` = (OpCode is LDR or STR).
  - `IsMem` = 1: `Address` = `Result[15:0]`.
  - `IsMem` = 0: `Address` = `PCInstruction`.
  - `Result[31:16]` is ignored; no fault is raised.
- `ReadWrite` = 1 only when OpCode == `OP_STR` and `Reset` = 0. Otherwise it is 0.
- `DataOut` = `Source2` when OpCode == `OP_STR`, else 32'h0.
- `LDR` register:
  - On a rising `Clock` with OpCode == `OP_LDR`: `LDR` <= `DataIn`.
  - Otherwise it holds its value.
- STR and non-memory opcodes never modify `LDR`.
- `Source1` has no effect on any output.

## Timing
- `Address`, `ReadWrite` and `DataOut` are combinational from the inputs, with zero-cycle latency. Memory must return `DataIn` in the same cycle (asynchronous-read memory).
- `LDR` has one-cycle latency: it shows `DataIn` after the rising edge that ends the LDR cycle.
- Reset (asynchronous, active-high):
  - `LDR` = 32'h0 immediately on assertion and while `Reset` is held.
  - `ReadWrite` is forced to 0 while `Reset` is high, so no stray write can occur.
  - `Address` and `DataOut` follow the combinational rules during reset.
- Reset asserted during an LDR cycle: the load is discarded and `LDR` stays 0. Deassertion is synchronous to normal operation; the first edge after release may capture.
- Back-to-back LDRs: each edge captures that cycle's `DataIn`.
- A store to the same address a load reads is not forwarded; ordering is the memory's responsibility.
- No handshake: one access per cycle, no stalls.

## Structure
- Shared package `mem_stage_pkg` holds:
  - `OP_LDR`, `OP_STR` (4-bit localparams).
  - Widths: `DATA_W` = 32, `ADDR_W` = 16, `OP_W` = 4.
  - Write-strobe constants `MEM_READ` = 0, `MEM_WRITE` = 1.
- One sub-module, `mux_2by1` (Select, In1, In2, Out; 32-bit):
  - Out = In1 when Select = 0, In2 when Select = 1.
  - Used for address selection with zero-extended 16-bit inputs; `Address` takes `Out[15:0]`.
- The `LDR` register lives in `memory_access_block`.

## Test plan
- Reset: assert `Reset` with OpCode = `OP_STR` → `ReadWrite` = 0 and `LDR` = 0. Release → `ReadWrite` = 1.
- Fetch: OpCode = 4'b0000, `PCInstruction` = 16'h0042, `Result` = 32'h1234 → `Address` = 16'h0042, `ReadWrite` = 0, `DataOut` = 0, `LDR` unchanged after the edge.
- Store: OpCode = `OP_STR`, `Result` = 32'hFFFF_0100, `Source2` = 32'hDEAD_BEEF → `Address` = 16'h0100, `ReadWrite` = 1, `DataOut` = 32'hDEAD_BEEF, `LDR` unchanged.
- Load: OpCode = `OP_LDR`, `Result` = 32'h0000_0200, `DataIn` = 32'hCAFE_F00D → `Address` = 16'h0200, `ReadWrite` = 0. After the next rising edge `LDR` = 32'hCAFE_F00D.
- Mid-load reset: LDR cycle with `DataIn` = 32'h1111_1111, `Reset` pulsed before the edge → `LDR` = 0. Next LDR with `DataIn` = 32'h2222_2222 → `LDR` = 32'h2222_2222.
- `mux_2by1` standalone: In1 = 32'hA5A5_A5A5, In2 = 32'h5A5A_5A5A; Select 0 → Out = 32'hA5A5_A5A5, Select 1 → Out = 32'h5A5A_5A5A.
